// File: rtl/ntt_stage_ctrl.sv
// Stage sequencer for one NTT: issues N_LOG2 butterfly stages, checks the address
// generator's end-of-stage flag, drains the butterfly pipeline and ping-pongs the banks.
module ntt_stage_ctrl #(
  parameter int N_LOG2  = 8,
  parameter int BFU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  input  logic              agen_last,
  output logic              busy,
  output logic              done,
  output logic              stage_start,
  output logic              agen_en,
  output logic [3:0]        stage,
  output logic              bank_sel,
  output logic [N_LOG2-1:0] rom_base,
  output logic              err
);

  localparam int CW = N_LOG2 - 1;
  localparam logic [CW-1:0]     BFLY_LAST  = '1;  // N/2-1 is all ones in CW bits
  localparam logic [3:0]        DRN_LAST   = 4'(BFU_LAT - 1);
  localparam logic [3:0]        STAGE_LAST = 4'(N_LOG2 - 1);
  localparam logic [N_LOG2-1:0] ROM_ONE    = {{(N_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [CW-1:0]     bfly_cnt_reg;
  logic [3:0]        drn_cnt_reg;
  logic [3:0]        stage_reg;
  logic              bank_sel_reg;
  logic [N_LOG2-1:0] rom_base_reg;
  logic              err_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              stage_start_reg;
  logic              bfly_at_last;

  assign bfly_at_last = (bfly_cnt_reg == BFLY_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      bfly_cnt_reg    <= '0;
      drn_cnt_reg     <= '0;
      stage_reg       <= '0;
      bank_sel_reg    <= 1'b0;
      rom_base_reg    <= ROM_ONE;
      err_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      stage_start_reg <= 1'b0;
    end else begin
      done_reg        <= 1'b0;
      stage_start_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg       <= S_ISSUE;
            stage_reg       <= '0;
            bank_sel_reg    <= 1'b0;
            rom_base_reg    <= ROM_ONE;
            bfly_cnt_reg    <= '0;
            err_reg         <= 1'b0;
            busy_reg        <= 1'b1;
            stage_start_reg <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_reg <= S_RUN;
        end
        S_RUN: begin
          // The count alone ends the stage; agen_last only feeds the error flag.
          if (!hold) begin
            if (agen_last != bfly_at_last) begin
              err_reg <= 1'b1;
            end
            if (bfly_at_last) begin
              state_reg    <= S_DRAIN;
              bfly_cnt_reg <= '0;
              drn_cnt_reg  <= '0;
            end else begin
              bfly_cnt_reg <= bfly_cnt_reg + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drn_cnt_reg == DRN_LAST) begin
            bank_sel_reg <= ~bank_sel_reg;
            if (stage_reg == STAGE_LAST) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg       <= S_ISSUE;
              stage_reg       <= stage_reg + 1'b1;
              rom_base_reg    <= rom_base_reg << 1;
              stage_start_reg <= 1'b1;
            end
          end else begin
            drn_cnt_reg <= drn_cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign agen_en     = (state_reg == S_RUN) & ~hold;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign stage_start = stage_start_reg;
  assign stage       = stage_reg;
  assign bank_sel    = bank_sel_reg;
  assign rom_base    = rom_base_reg;
  assign err         = err_reg;

endmodule

// File: doc/ntt_stage_ctrl.md
# ntt_stage_ctrl

Stage sequencer for the NTT core. It runs one NTT of N = 2^N_LOG2 coefficients as N_LOG2 butterfly stages. For each stage it starts the address generator, gates it with `hold`, and checks its end-of-stage flag against an internal butterfly count. It then drains the butterfly pipeline before the next stage and alternates the ping-pong RAM banks. It sits between the top-level command interface and the address generator, butterfly unit and twiddle ROM.

## Interface
- `N_LOG2`, 8: log2 of the transform length; legal range 2..15.
- `BFU_LAT`, 4: butterfly-unit pipeline latency in cycles; legal range 1..15.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request one full transform; sampled only in IDLE.
- `hold`  in  1  upstream stall; freezes butterfly issue during RUN only.
- `agen_last`  in  1  address generator flags its final butterfly of the stage.
- `busy`  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- `done`  out  1  one-cycle pulse at transform completion.
- `stage_start`  out  1  one-cycle pulse in ISSUE; restarts the address generator.
- `agen_en`  out  1  address generator / butterfly issue enable; equals RUN & ~hold.
- `stage`  out  4  current stage index, 0..N_LOG2-1.
- `bank_sel`  out  1  read bank for the current stage; the write bank is ~bank_sel.
- `rom_base`  out  N_LOG2  twiddle ROM base for the current stage, equal to 1<<stage.
- `err`  out  1  sticky `agen_last` mismatch flag; cleared on an accepted start.

## Operation
- **State machine states:** IDLE, ISSUE, RUN, DRAIN, DONE.
- **Counters:** `bfly_cnt` is N_LOG2-1 bits wide and counts enabled RUN cycles. `drn_cnt` is 4 bits wide and counts DRAIN cycles.
- **IDLE:** start=1 accepts a transform and moves to ISSUE. Acceptance clears `stage`, `bank_sel`, `bfly_cnt` and `err`.
- **ISSUE:** lasts exactly 1 cycle with stage_start=1, then moves to RUN.
- **RUN:**
  - agen_en=~hold. `bfly_cnt` increments only when agen_en=1.
  - In the cycle where agen_en=1 and bfly_cnt=N/2-1, the block moves to DRAIN and clears `bfly_cnt` and `drn_cnt`.
  - `agen_last` is sampled only when agen_en=1.
  - err is set if agen_last=1 while bfly_cnt≠N/2-1, or if agen_last=0 when bfly_cnt=N/2-1.
  - The stage end is decided by `bfly_cnt`, never by `agen_last`.
- **DRAIN:**
  - lasts BFU_LAT cycles; `hold` is ignored.
  - On the last DRAIN cycle: `bank_sel` toggles, and the block moves to DONE if stage=N_LOG2-1.
  - Otherwise `stage` increments and the block moves to ISSUE.
- **DONE:** lasts 1 cycle with done=1, then moves to IDLE.
  - `bank_sel` now names the bank holding the result: N_LOG2 mod 2.
  - `stage`, `bank_sel` and `err` hold their values until the next accepted start.
- **start outside IDLE:** ignored, including in the DONE cycle.
- **agen_last outside RUN:** ignored and does not set err.
- **Reset:** rst_n=0 at any edge, including mid-transform, forces IDLE at that edge. Reset values: busy=0, done=0, stage_start=0, agen_en=0, stage=0, bank_sel=0, rom_base=1, err=0.

## Timing
- start is sampled at edge E0. Cycle k is the cycle following edge E(k-1).
- **Stage s (0-based), without hold:**
  - ISSUE is cycle 1+s·P, where P = 1+N/2+BFU_LAT.
  - RUN occupies the next N/2 cycles.
  - DRAIN occupies the following BFU_LAT cycles.
- **Completion:** DONE, with done=1, is cycle N_LOG2·P+1. busy falls in the cycle after that.
- **Each hold cycle in RUN:** extends RUN by exactly one cycle and delays everything after it by one cycle.
- **Output timing:** agen_en is combinational from state and hold. All other outputs are registered.
- **Earliest restart:** a new start is accepted at the edge ending the first IDLE cycle after DONE.

## Test plan
1. **Basic run:** N_LOG2=3, BFU_LAT=2; start pulse at E0 with agen_last correct on every stage -> stage_start in cycles 1, 8 and 15; done=1 in cycle 22 only; busy high for cycles 1-22; err=0; bank_sel=1 at done.
2. **Hold:** hold=1 for 3 cycles in the middle of stage-1 RUN -> agen_en=0 for exactly those 3 cycles; done moves to cycle 25; bfly_cnt does not advance during hold.
3. **agen_last mismatch:**
   - agen_last asserted at bfly_cnt=1 in stage 0 -> err=1 from the next cycle; the stage still ends after 4 enabled cycles; done still in cycle 22; err stays 1 until the next start.
   - Second run with agen_last never asserted -> err=1.
4. **Start while busy:** start held high continuously from E0 -> exactly one transform; the next is accepted in the IDLE cycle after DONE; stage_start in cycle 24 (cycle 23 is IDLE).
5. **Reset mid-run:** rst_n=0 for 1 cycle during stage-2 DRAIN -> all outputs at reset values from the next cycle; no done pulse; a new start behaves exactly as in scenario 1.
6. **Default parameters:** N_LOG2=8, BFU_LAT=4 -> rom_base is 1, 2, 4, …, 128 across the stages; done in cycle 8·133+1=1065; bank_sel=0 at done.
